// File: rtl/scan_pattern_driver_if.sv
// Scan driver bus: run request, five scan chain connections and status/result signals.
// master is the driver side, slave is the core/environment side.
interface scan_pattern_driver_if;
  logic        start;
  logic        scan_out0;
  logic        scan_out1;
  logic        scan_out2;
  logic        scan_out3;
  logic        scan_out4;
  logic        scan_in0;
  logic        scan_in1;
  logic        scan_in2;
  logic        scan_in3;
  logic        scan_in4;
  logic        scan_enable;
  logic        test_mode;
  logic        busy;
  logic        done;
  logic [15:0] signature;

  modport master (
    input  start,
    input  scan_out0, scan_out1, scan_out2, scan_out3, scan_out4,
    output scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
    output scan_enable, test_mode, busy, done, signature
  );

  modport slave (
    output start,
    output scan_out0, scan_out1, scan_out2, scan_out3, scan_out4,
    input  scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
    input  scan_enable, test_mode, busy, done, signature
  );
endinterface

// File: rtl/scan_pattern_driver.sv
// Scan pattern driver: loads LFSR patterns into five scan chains, pulses capture,
// compresses chain responses into a 16-bit MISR and reports the signature.
module scan_pattern_driver #(
  parameter int unsigned CHAIN_LEN    = 32,
  parameter int unsigned NUM_PATTERNS = 16,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input logic                   clk,
  input logic                   reset,
  scan_pattern_driver_if.master bus
);

  localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CntW-1:0] LastShift = CntW'(CHAIN_LEN - 1);
  localparam logic [7:0] NumPat = 8'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StShift,
    StUnload,
    StFinish
  } state_e;

  // Shared by the pattern LFSR and the MISR: x^16+x^14+x^13+x^11+1, shift left.
  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] shift_cnt_q, shift_cnt_d;
  logic [7:0]      pat_cnt_q, pat_cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     misr_q, misr_d;
  logic [15:0]     misr_next;
  logic [4:0]      scan_out_vec;
  logic            last_shift;

  logic [4:0]      scan_in_q;
  logic            scan_enable_q;
  logic            test_mode_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     signature_q;

  assign scan_out_vec = {bus.scan_out4, bus.scan_out3, bus.scan_out2, bus.scan_out1,
                         bus.scan_out0};
  assign last_shift   = (shift_cnt_q == LastShift);
  assign misr_next    = step16(misr_q) ^ {11'd0, scan_out_vec};

  // Next-state logic: phase sequencing, counters, LFSR advance and MISR compression.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StLoad;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
          lfsr_d      = SEED;
          misr_d      = '0;
        end
      end
      StLoad: begin
        lfsr_d      = step16(lfsr_q);
        shift_cnt_d = last_shift ? '0 : shift_cnt_q + CntW'(1);
        if (last_shift) state_d = StCapture;
      end
      StCapture: begin
        pat_cnt_d = pat_cnt_q + 8'd1;
        state_d   = (pat_cnt_d < NumPat) ? StShift : StUnload;
      end
      StShift: begin
        // Unload the previous response while the next pattern shifts in.
        lfsr_d      = step16(lfsr_q);
        misr_d      = misr_next;
        shift_cnt_d = last_shift ? '0 : shift_cnt_q + CntW'(1);
        if (last_shift) state_d = StCapture;
      end
      StUnload: begin
        misr_d      = misr_next;
        shift_cnt_d = last_shift ? '0 : shift_cnt_q + CntW'(1);
        if (last_shift) state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Core state: FSM, counters, LFSR and MISR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      lfsr_q      <= SEED;
      misr_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
    end
  end

  // Outputs registered from next state so they line up with the phase they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_in_q     <= '0;
      scan_enable_q <= 1'b0;
      test_mode_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      signature_q   <= '0;
    end else begin
      scan_in_q     <= (state_d == StLoad || state_d == StShift) ? lfsr_d[4:0] : 5'd0;
      scan_enable_q <= (state_d == StLoad || state_d == StShift || state_d == StUnload);
      test_mode_q   <= (state_d != StIdle);
      busy_q        <= (state_d != StIdle);
      done_q        <= (state_d == StFinish);
      if (state_d == StFinish) signature_q <= misr_d;
    end
  end

  assign bus.scan_in0    = scan_in_q[0];
  assign bus.scan_in1    = scan_in_q[1];
  assign bus.scan_in2    = scan_in_q[2];
  assign bus.scan_in3    = scan_in_q[3];
  assign bus.scan_in4    = scan_in_q[4];
  assign bus.scan_enable = scan_enable_q;
  assign bus.test_mode   = test_mode_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.signature   = signature_q;

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Directed bench for scan_pattern_driver: default instance (32x16) and a tiny one (2x1).
module tb_scan_pattern_driver;

  localparam int unsigned CL_A  = 32;
  localparam int unsigned NP_A  = 16;
  localparam int unsigned CL_B  = 2;
  localparam int unsigned NP_B  = 1;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          LIMIT = 2000;

  typedef enum int {PhLoad, PhCapture, PhShift, PhUnload, PhFinish, PhAfter} phase_e;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  scan_pattern_driver_if bus_a ();
  scan_pattern_driver_if bus_b ();

  scan_pattern_driver #(
    .CHAIN_LEN    (CL_A),
    .NUM_PATTERNS (NP_A),
    .SEED         (SEED)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a_n),
    .bus   (bus_a)
  );

  scan_pattern_driver #(
    .CHAIN_LEN    (CL_B),
    .NUM_PATTERNS (NP_B),
    .SEED         (SEED)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b_n),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Phase of cycle c, where cycle 0 is the cycle whose closing edge samples start.
  function automatic phase_e phase(input int c, input int cl, input int np);
    int p;
    if (c <= cl) return PhLoad;
    p = c - cl - 1;
    if (p < np * (cl + 1)) begin
      if (p % (cl + 1) == 0) return PhCapture;
      return (p / (cl + 1) == np - 1) ? PhUnload : PhShift;
    end
    if (p == np * (cl + 1)) return PhFinish;
    return PhAfter;
  endfunction

  // One run on instance A with a cycle-by-cycle model of every output.
  // len = cycles from start-sampling cycle to done cycle inclusive (0 if no done).
  task automatic run_a(input bit rnd, input int pulse_at, input int abort_at,
                       output int len, output int iso, output int errs,
                       output logic [7:0] first, output logic [15:0] sig);
    logic [15:0] l;
    logic [4:0]  so;
    logic [4:0]  si;
    logic [4:0]  exp_si;
    logic        se_p1;
    logic        se_p2;
    phase_e      ph;
    l = SEED; sig = '0; len = 0; iso = 0; errs = 0; first = '0; se_p1 = 1'b0; se_p2 = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      if (c == abort_at) return;
      ph     = phase(c, CL_A, NP_A);
      si     = {bus_a.scan_in4, bus_a.scan_in3, bus_a.scan_in2, bus_a.scan_in1, bus_a.scan_in0};
      exp_si = (ph == PhLoad || ph == PhShift) ? l[4:0] : 5'd0;
      if (c == 1) first = {si, bus_a.scan_enable, bus_a.test_mode, bus_a.busy};
      if (si !== exp_si) errs++;
      if (bus_a.scan_enable !== (ph == PhLoad || ph == PhShift || ph == PhUnload)) errs++;
      if (bus_a.busy !== (ph != PhAfter) || bus_a.test_mode !== (ph != PhAfter)) errs++;
      if (bus_a.done !== (ph == PhFinish)) errs++;
      if (se_p2 && !se_p1 && bus_a.scan_enable) iso++;
      se_p2 = se_p1;
      se_p1 = bus_a.scan_enable;
      if (bus_a.done === 1'b1) begin
        len = c + 1;
        return;
      end
      so = rnd ? 5'($urandom) : 5'd0;
      {bus_a.scan_out4, bus_a.scan_out3, bus_a.scan_out2, bus_a.scan_out1, bus_a.scan_out0} = so;
      if (ph == PhShift || ph == PhUnload) sig = step16(sig) ^ {11'd0, so};
      if (ph == PhLoad || ph == PhShift) l = step16(l);
      bus_a.start = (c == pulse_at);
    end
  endtask

  initial begin
    int          len;
    int          iso;
    int          errs;
    int          hits;
    logic [7:0]  first;
    logic [15:0] model;
    logic        se_cap;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    {bus_a.scan_out4, bus_a.scan_out3, bus_a.scan_out2, bus_a.scan_out1, bus_a.scan_out0} = '0;
    {bus_b.scan_out4, bus_b.scan_out3, bus_b.scan_out2, bus_b.scan_out1, bus_b.scan_out0} = '0;
    #1;
    check("reset scan_in", {bus_a.scan_in4, bus_a.scan_in3, bus_a.scan_in2, bus_a.scan_in1,
                            bus_a.scan_in0}, 0);
    check("reset scan_enable", bus_a.scan_enable, 0);
    check("reset test_mode", bus_a.test_mode, 0);
    check("reset busy", bus_a.busy, 0);
    check("reset done", bus_a.done, 0);
    check("reset signature", bus_a.signature, 0);
    check("reset b signature", bus_b.signature, 0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    check("idle without start busy", bus_a.busy, 0);

    // Defaults, chains tied low.
    run_a(1'b0, 0, 0, len, iso, errs, first, model);
    check("first LOAD {scan_in,se,tm,busy}", first, 8'b00001_111);
    check("run length zeros", len, 562);
    check("signature zeros", bus_a.signature, 16'h0000);
    check("stream zeros", errs, 0);
    check("isolated capture cycles", iso, 16);
    @(negedge clk);
    check("done one cycle", bus_a.done, 0);
    check("busy drops after run", bus_a.busy, 0);

    // Random chain responses against the reference MISR, then signature hold.
    run_a(1'b1, 0, 0, len, iso, errs, first, model);
    check("run length random", len, 562);
    check("signature random", bus_a.signature, model);
    check("stream random", errs, 0);
    repeat (10) @(negedge clk);
    check("signature held", bus_a.signature, model);
    {bus_a.scan_out4, bus_a.scan_out3, bus_a.scan_out2, bus_a.scan_out1, bus_a.scan_out0} = '0;

    // start pulsed in the middle of a SHIFT phase is ignored.
    run_a(1'b0, 100, 0, len, iso, errs, first, model);
    check("run length with busy start", len, 562);
    check("stream with busy start", errs, 0);

    // Redo the random run so the signature is nonzero before the abort.
    run_a(1'b1, 0, 0, len, iso, errs, first, model);
    check("signature before abort", bus_a.signature, model);
    {bus_a.scan_out4, bus_a.scan_out3, bus_a.scan_out2, bus_a.scan_out1, bus_a.scan_out0} = '0;

    // Abort at cycle 100 with an asynchronous reset.
    run_a(1'b0, 0, 100, len, iso, errs, first, model);
    check("stream before abort", errs, 0);
    #2 rst_a_n = 1'b0;
    #1;
    check("abort scan_in", {bus_a.scan_in4, bus_a.scan_in3, bus_a.scan_in2, bus_a.scan_in1,
                            bus_a.scan_in0}, 0);
    check("abort scan_enable", bus_a.scan_enable, 0);
    check("abort test_mode", bus_a.test_mode, 0);
    check("abort busy", bus_a.busy, 0);
    check("abort done", bus_a.done, 0);
    check("abort signature", bus_a.signature, 0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) rst_a_n = 1'b1;
      if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) hits++;
    end
    check("no done or restart after abort", hits, 0);
    run_a(1'b0, 0, 0, len, iso, errs, first, model);
    check("rerun length", len, 562);
    check("rerun signature", bus_a.signature, 16'h0000);
    check("rerun isolated captures", iso, 16);
    check("rerun stream", errs, 0);

    // Tiny instance: compress 1 then 0 on scan_out0 -> MISR 0x0001, 0x0002.
    @(negedge clk);
    bus_b.start = 1'b1;
    len = 0;
    se_cap = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      if (c == 3) se_cap = bus_b.scan_enable;
      if (bus_b.done === 1'b1) begin
        len = c + 1;
        break;
      end
      bus_b.scan_out0 = (c == 4);
    end
    check("b capture scan_enable", se_cap, 0);
    check("b run length", len, 7);
    check("b signature", bus_b.signature, 16'h0002);

    // start held high through FINISH relaunches from IDLE one cycle later.
    bus_b.start = 1'b1;
    @(negedge clk);
    check("b idle between runs busy", bus_b.busy, 0);
    check("b idle between runs done", bus_b.done, 0);
    len = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check("b relaunch busy", bus_b.busy, 1);
      if (bus_b.done === 1'b1) begin
        len = c + 1;
        break;
      end
    end
    bus_b.start = 1'b0;
    check("b held-start run length", len, 7);
    check("b held-start signature", bus_b.signature, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("b stays idle after start drop", bus_b.busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
